// File: rtl/hangman_pkg.sv
// Shared types and constants for the Hangman round controller.
//   state_e : round FSM states
//   cls_e   : classification of one accepted guess
//   *_DEF   : default alphabet size and miss limit
//   LTR_*   : letter index of each English letter in the masks
package hangman_pkg;

    localparam int ALPHA_DEF     = 26;
    localparam int MAX_WRONG_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_WIN,
        ST_LOSE
    } state_e;

    typedef enum logic [1:0] {
        CLS_BAD,
        CLS_DUP,
        CLS_HIT,
        CLS_MISS
    } cls_e;

    localparam int LTR_A = 0,  LTR_B = 1,  LTR_C = 2,  LTR_D = 3,  LTR_E = 4;
    localparam int LTR_F = 5,  LTR_G = 6,  LTR_H = 7,  LTR_I = 8,  LTR_J = 9;
    localparam int LTR_K = 10, LTR_L = 11, LTR_M = 12, LTR_N = 13, LTR_O = 14;
    localparam int LTR_P = 15, LTR_Q = 16, LTR_R = 17, LTR_S = 18, LTR_T = 19;
    localparam int LTR_U = 20, LTR_V = 21, LTR_W = 22, LTR_X = 23, LTR_Y = 24;
    localparam int LTR_Z = 25;

endpackage

// File: rtl/hangman_guess_classify.sv
// Combinational classifier for one guess.
//   idx_i          : guessed letter index
//   guessed_i      : letters guessed so far
//   word_i         : latched word letter-presence mask
//   cls_o          : BAD (out of range) > DUP > HIT > MISS
//   next_guessed_o : guessed mask with this letter added (unchanged for BAD/DUP)
module hangman_guess_classify
    import hangman_pkg::*;
#(
    parameter int ALPHA = ALPHA_DEF,
    parameter int XW    = 5
) (
    input  logic [XW-1:0]    idx_i,
    input  logic [ALPHA-1:0] guessed_i,
    input  logic [ALPHA-1:0] word_i,
    output cls_e             cls_o,
    output logic [ALPHA-1:0] next_guessed_o
);

    logic [ALPHA-1:0] sel;
    logic             in_range;

    always_comb begin
        // One-hot decode; stays all-zero for an out-of-range index, so the
        // OR below leaves the mask untouched for BAD, and DUP re-sets a set bit.
        sel = '0;
        for (int i = 0; i < ALPHA; i++) begin
            sel[i] = (int'(idx_i) == i);
        end
        in_range = (int'(idx_i) < ALPHA);

        if (!in_range)                cls_o = CLS_BAD;
        else if (|(sel & guessed_i))  cls_o = CLS_DUP;
        else if (|(sel & word_i))     cls_o = CLS_HIT;
        else                          cls_o = CLS_MISS;

        next_guessed_o = guessed_i | sel;
    end

endmodule

// File: rtl/hangman_round_ctrl.sv
// Guess-tracking controller for one Hangman round.
//   clk, reset           : clock, synchronous active-high reset
//   start_i              : begin a new round, latching word_mask_i
//   word_mask_i          : letter-presence mask of the secret word
//   guess_valid_i/idx_i  : guess handshake (accepted only in PLAY, not with start)
//   guess_ready_o        : high in PLAY
//   guessed_mask_o       : letters guessed this round
//   reveal_mask_o        : guessed letters that are in the word
//   wrong_count_o        : misses this round, saturating at MAX_WRONG
//   hit/miss/dup/bad_idx : one-cycle result pulse per accepted guess
//   playing/win/lose     : state decode
module hangman_round_ctrl
    import hangman_pkg::*;
#(
    parameter int ALPHA     = ALPHA_DEF,
    parameter int XW        = 5,
    parameter int MAX_WRONG = MAX_WRONG_DEF,
    parameter int CW        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [ALPHA-1:0] word_mask_i,
    input  logic             guess_valid_i,
    input  logic [XW-1:0]    guess_idx_i,
    output logic             guess_ready_o,
    output logic [ALPHA-1:0] guessed_mask_o,
    output logic [ALPHA-1:0] reveal_mask_o,
    output logic [CW-1:0]    wrong_count_o,
    output logic             hit_o,
    output logic             miss_o,
    output logic             dup_o,
    output logic             bad_idx_o,
    output logic             playing_o,
    output logic             win_o,
    output logic             lose_o
);

    localparam logic [CW-1:0] MAX_W = CW'(MAX_WRONG);

    state_e           state_q;
    logic [ALPHA-1:0] word_q;
    logic [ALPHA-1:0] guessed_q;
    logic [CW-1:0]    wrong_q;
    logic             hit_q, miss_q, dup_q, bad_q;

    cls_e             cls;
    logic [ALPHA-1:0] guessed_d;
    logic [CW-1:0]    wrong_d;

    hangman_guess_classify #(
        .ALPHA (ALPHA),
        .XW    (XW)
    ) u_classify (
        .idx_i          (guess_idx_i),
        .guessed_i      (guessed_q),
        .word_i         (word_q),
        .cls_o          (cls),
        .next_guessed_o (guessed_d)
    );

    // Saturating: never step past the miss limit.
    assign wrong_d = (wrong_q == MAX_W) ? wrong_q : wrong_q + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            guessed_q <= '0;
            wrong_q   <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            dup_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            dup_q  <= 1'b0;
            bad_q  <= 1'b0;

            if (start_i) begin
                // A same-cycle guess is dropped silently.
                word_q    <= word_mask_i;
                guessed_q <= '0;
                wrong_q   <= '0;
                state_q   <= (word_mask_i == '0) ? ST_WIN : ST_PLAY;
            end else if (guess_valid_i && state_q == ST_PLAY) begin
                unique case (cls)
                    CLS_BAD: bad_q <= 1'b1;
                    CLS_DUP: dup_q <= 1'b1;
                    CLS_HIT: begin
                        hit_q     <= 1'b1;
                        guessed_q <= guessed_d;
                        if ((guessed_d & word_q) == word_q) state_q <= ST_WIN;
                    end
                    CLS_MISS: begin
                        miss_q    <= 1'b1;
                        guessed_q <= guessed_d;
                        wrong_q   <= wrong_d;
                        if (wrong_d == MAX_W) state_q <= ST_LOSE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign playing_o      = (state_q == ST_PLAY);
    assign win_o          = (state_q == ST_WIN);
    assign lose_o         = (state_q == ST_LOSE);
    assign guess_ready_o  = playing_o;
    assign guessed_mask_o = guessed_q;
    assign reveal_mask_o  = guessed_q & word_q;
    assign wrong_count_o  = wrong_q;
    assign hit_o          = hit_q;
    assign miss_o         = miss_q;
    assign dup_o          = dup_q;
    assign bad_idx_o      = bad_q;

endmodule

// File: doc/hangman_round_ctrl.md
Name: hangman_round_ctrl

Overview:
Parametrised guess-tracking controller for one Hangman round. Latches the secret word's letter-presence mask on start, accepts guesses through a valid/ready handshake, keeps a guessed-letter mask and a wrong-guess counter, and ends the round in WIN or LOSE. It sits between the keyboard/guess decoder and the display/score logic. Beyond the single-cycle original, it adds configurable alphabet size and miss limit, duplicate-guess filtering, range checking, and an explicit round FSM.

Parameters:
ALPHA, 26, number of letter slots (mask width)
XW, 5, guess index width; must satisfy 2**XW >= ALPHA
MAX_WRONG, 6, misses that end the round in LOSE (1..2**CW-1)
CW, 3, wrong_count width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  pulse; latch word_mask and begin a new round
word_mask  in  ALPHA  bit i=1 means letter i appears in the word; sampled only on start
guess_valid  in  1  guess present
guess_idx  in  XW  letter index of the guess
guess_ready  out  1  high only in PLAY
guessed_mask  out  ALPHA  letters guessed so far, hits and misses
reveal_mask  out  ALPHA  guessed_mask & latched word mask; drives the display
wrong_count  out  CW  misses this round
hit  out  1  one-cycle pulse: new correct letter
miss  out  1  one-cycle pulse: new wrong letter
dup  out  1  one-cycle pulse: letter already guessed
bad_idx  out  1  one-cycle pulse: guess_idx >= ALPHA
playing, win, lose  out  1 each  state decode; at most one is high

Behaviour:
- States: IDLE, PLAY, WIN, LOSE. Reset puts the block in IDLE.
- Reset values: all masks 0, wrong_count 0, all pulses 0, playing/win/lose 0, guess_ready 0.
- start in any state, when not in reset:
  - Latch word_mask, clear guessed_mask and wrong_count.
  - Next state is PLAY, or WIN if word_mask==0.
  - start has priority over a same-cycle guess. That guess is dropped with no pulse.
- A guess is accepted when guess_valid && guess_ready && !start. The result is registered and visible in the cycle after acceptance (latency 1).
- Classification of an accepted guess, in priority order:
  - guess_idx >= ALPHA: bad_idx pulse, no state change.
  - guessed_mask[idx]==1: dup pulse, no penalty, no change.
  - word bit 1: set the guessed bit, hit pulse.
  - word bit 0: set the guessed bit, wrong_count+1, miss pulse.
- Win check uses the updated mask: (next_guessed & word_q) == word_q moves to WIN in the same edge as the hit pulse.
- Lose check: wrong_count reaching MAX_WRONG moves to LOSE in the same edge as the miss pulse. The counter saturates there and never wraps.
- WIN and LOSE hold until start or reset. In these states guess_ready=0, so guesses are ignored with no pulses.
- A guess_valid while IDLE is ignored.
- Exactly one of hit/miss/dup/bad_idx pulses per accepted guess; none otherwise.
- Reset mid-round returns to IDLE and clears everything. Any pending guess is lost.

Decomposition:
- Shared package hangman_pkg holds:
  - State enum (IDLE/PLAY/WIN/LOSE).
  - Defaults ALPHA=26, MAX_WRONG=6.
  - Letter-index constants (LTR_A=0..LTR_Z=25).
- One sub-module, hangman_guess_classify, is natural. It is combinational: it takes idx, guessed_mask and word_q, and returns the class (bad/dup/hit/miss) plus next_guessed.
- The FSM, counter and output registers stay in the top.

Test Plan:
- Win path: start with word_mask=26'h0000007 ("ABC"); guesses 0, 1, 2 on consecutive cycles -> three hit pulses; win=1 one cycle after the third; wrong_count=0; reveal_mask=26'h7.
- Lose path: start with mask 26'h7; guesses 3,4,5,6,7,8 -> six miss pulses; lose=1 with the sixth; wrong_count=6; a seventh guess is ignored and guess_ready=0.
- Duplicates and range: in PLAY, guess 3 twice -> miss then dup, wrong_count stays 1; guess 27 -> bad_idx only, masks unchanged.
- Priority: start and guess_valid (idx 0) in the same cycle during PLAY -> no pulse; guessed_mask=0 and wrong_count=0 next cycle; state PLAY.
- Edge cases: start with word_mask=0 -> win=1 next cycle. Assert reset while wrong_count=4 -> next cycle IDLE with all outputs 0.
- Parametric: ALPHA=10, XW=4, MAX_WRONG=2; guesses 12, then 9 against mask 10'h001 -> bad_idx, then miss; one more miss -> lose.
